pipelined_decode_ctrl: RTL and testbench

Registered decode stage for the pipelined OTTER. Decodes the RV32I (+ optional M) instruction held in IF/ID into control signals and drives the ID/EX control register. Adds what the plain decoder lacks: load-use hazard bubbles, multi-cycle mul/div sequencing, downstream stall and flush handling, and illegal-instruction flagging.

---
 rtl/pipelined_decode_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipelined_decode_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_decode_ctrl.sv
// pipelined_decode_ctrl: RV32I(+M) decode stage driving the ID/EX control register, with
// load-use bubbles, mul/div occupancy, stall/flush handling and illegal-instruction flagging.
module pipelined_decode_ctrl #(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        InstrValid,
  input  logic [31:0] Instr,
  input  logic        Flush,
  input  logic        ExStall,
  output logic        IdStall,
  output logic        MdBusy,
  output logic        ExValid,
  output logic        ExRegWrite,
  output logic [1:0]  ExResultSrc,
  output logic        ExMemWrite,
  output logic [1:0]  ExMemSize,
  output logic        ExMemSign,
  output logic        ExJump,
  output logic        ExBranch,
  output logic [4:0]  ExALUControl,
  output logic        ExALUSrc,
  output logic [2:0]  ExImmSrc,
  output logic [4:0]  ExRd,
  output logic        ExMulDiv,
  output logic        IllegalInstr
);
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_sign;
    logic       jump;
    logic       branch;
    logic [4:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] imm_src;
    logic [4:0] rd;
    logic       mul_div;
    logic       illegal;
  } ctrl_t;

  localparam int MAX_CYCLES = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_m_enc, is_md;
  logic legal, writes, rs1_used, rs2_used, load_use;
  ctrl_t dec, ex;
  logic ex_valid;
  logic [CW-1:0] cnt;

  assign op       = Instr[6:0];
  assign f3       = Instr[14:12];
  assign rs1      = Instr[19:15];
  assign rs2      = Instr[24:20];
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;
  assign is_m_enc = is_op && Instr[31:25] == 7'b0000001;
  assign is_md    = is_m_enc && ENABLE_M != 0;
  assign legal    = (is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_opi | is_op)
                    & !(is_m_enc & !is_md);
  assign writes   = !(is_br | is_st);

  always_comb begin
    dec = '0;
    dec.illegal = !legal;
    if (legal) begin
      dec.reg_write  = writes;
      dec.result_src = is_ld ? 2'd1 : (is_auipc | is_jal | is_jalr) ? 2'd2 : 2'd0;
      dec.mem_write  = is_st;
      dec.mem_size   = Instr[13:12];
      dec.mem_sign   = Instr[14];
      dec.jump       = is_jal | is_jalr;
      dec.branch     = is_br;
      dec.alu_ctrl   = is_lui ? 5'b01001 : (is_ld | is_st) ? 5'b00000 : is_md ? {2'b10, f3}
                       : {is_br, is_opi ? (f3 == 3'b101 && Instr[30]) : Instr[30], f3};
      dec.alu_src    = is_lui | is_ld | is_opi | is_st;
      dec.imm_src    = (is_jalr | is_ld | is_opi) ? 3'd1 : is_st ? 3'd2 : is_br ? 3'd3
                       : (is_lui | is_auipc) ? 3'd4 : is_jal ? 3'd5 : 3'd0;
      dec.rd         = writes ? Instr[11:7] : 5'd0;
      dec.mul_div    = is_md;
    end
  end

  // A load in EX whose rd feeds the instruction in ID needs one bubble
  assign rs1_used = !(is_lui | is_auipc | is_jal);
  assign rs2_used = is_op | is_st | is_br;
  assign load_use = ex_valid && ex.result_src == 2'd1 && ex.rd != 5'd0 && InstrValid
                    && ((rs1_used && rs1 == ex.rd) || (rs2_used && rs2 == ex.rd));
  assign MdBusy   = cnt != '0;
  assign IdStall  = !Flush && (ExStall || MdBusy || load_use);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid <= 1'b0;
      ex       <= '0;
      cnt      <= '0;
    end else if (Flush) begin
      ex_valid <= 1'b0;
      ex       <= '0;
      cnt      <= '0;
    end else if (ExStall || MdBusy) begin
      cnt <= MdBusy ? cnt - CW'(1) : cnt;
    end else if (load_use) begin
      ex_valid <= 1'b0;
      ex       <= '0;
    end else begin
      ex_valid <= InstrValid;
      ex       <= InstrValid ? dec : '0;
      cnt      <= (InstrValid && dec.mul_div) ? (f3[2] ? DIV_LOAD : MUL_LOAD) : '0;
    end
  end

  assign ExValid      = ex_valid;
  assign ExRegWrite   = ex.reg_write;
  assign ExResultSrc  = ex.result_src;
  assign ExMemWrite   = ex.mem_write;
  assign ExMemSize    = ex.mem_size;
  assign ExMemSign    = ex.mem_sign;
  assign ExJump       = ex.jump;
  assign ExBranch     = ex.branch;
  assign ExALUControl = ex.alu_ctrl;
  assign ExALUSrc     = ex.alu_src;
  assign ExImmSrc     = ex.imm_src;
  assign ExRd         = ex.rd;
  assign ExMulDiv     = ex.mul_div;
  assign IllegalInstr = ex.illegal;
endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// tb_pipelined_decode_ctrl: directed vectors with a queue-based scoreboard; a separate
// monitor pops expected ID/EX state and IdStall values and compares them each cycle.
module tb_pipelined_decode_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic InstrValid = 1'b0, Flush = 1'b0, ExStall = 1'b0;
  logic [31:0] Instr = '0;
  logic IdStall, MdBusy, ExValid, ExRegWrite, ExMemWrite, ExMemSign, ExJump, ExBranch;
  logic ExALUSrc, ExMulDiv, IllegalInstr;
  logic [1:0] ExResultSrc, ExMemSize;
  logic [4:0] ExALUControl, ExRd;
  logic [2:0] ExImmSrc;
  logic n_IdStall, n_MdBusy, n_ExValid, n_ExRegWrite, n_ExMemWrite, n_ExMemSign, n_ExJump;
  logic n_ExBranch, n_ExALUSrc, n_ExMulDiv, n_Illegal;
  logic [1:0] n_ExResultSrc, n_ExMemSize;
  logic [4:0] n_ExALUControl, n_ExRd;
  logic [2:0] n_ExImmSrc;

  always #5 clk = ~clk;

  pipelined_decode_ctrl #(.ENABLE_M(1), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut (
    .CLK(clk), .RST_N(rst_n), .InstrValid(InstrValid), .Instr(Instr), .Flush(Flush),
    .ExStall(ExStall), .IdStall(IdStall), .MdBusy(MdBusy), .ExValid(ExValid),
    .ExRegWrite(ExRegWrite), .ExResultSrc(ExResultSrc), .ExMemWrite(ExMemWrite),
    .ExMemSize(ExMemSize), .ExMemSign(ExMemSign), .ExJump(ExJump), .ExBranch(ExBranch),
    .ExALUControl(ExALUControl), .ExALUSrc(ExALUSrc), .ExImmSrc(ExImmSrc), .ExRd(ExRd),
    .ExMulDiv(ExMulDiv), .IllegalInstr(IllegalInstr));

  pipelined_decode_ctrl #(.ENABLE_M(0), .MUL_CYCLES(1), .DIV_CYCLES(4)) dut_nm (
    .CLK(clk), .RST_N(rst_n), .InstrValid(InstrValid), .Instr(Instr), .Flush(Flush),
    .ExStall(ExStall), .IdStall(n_IdStall), .MdBusy(n_MdBusy), .ExValid(n_ExValid),
    .ExRegWrite(n_ExRegWrite), .ExResultSrc(n_ExResultSrc), .ExMemWrite(n_ExMemWrite),
    .ExMemSize(n_ExMemSize), .ExMemSign(n_ExMemSign), .ExJump(n_ExJump), .ExBranch(n_ExBranch),
    .ExALUControl(n_ExALUControl), .ExALUSrc(n_ExALUSrc), .ExImmSrc(n_ExImmSrc), .ExRd(n_ExRd),
    .ExMulDiv(n_ExMulDiv), .IllegalInstr(n_Illegal));

  typedef struct { string tag; logic v; logic b; logic [24:0] c; logic nm; } ex_t;
  typedef struct { string tag; logic s; } st_t;
  ex_t ex_q[$];
  st_t st_q[$];
  int n_cmp = 0, n_bad = 0;
  logic done = 1'b0, nm_chk = 1'b0;
  logic [24:0] got_c;
  assign got_c = {ExRegWrite, ExResultSrc, ExMemWrite, ExMemSize, ExMemSign, ExJump, ExBranch,
                  ExALUControl, ExALUSrc, ExImmSrc, ExRd, ExMulDiv, IllegalInstr};

  localparam logic [31:0] I_ADDI = 32'h00500093, I_LW2 = 32'h0000A103, I_ADD = 32'h001101B3;
  localparam logic [31:0] I_LW0 = 32'h0000A003, I_ADD0 = 32'h001001B3, I_SW = 32'h0020A223;
  localparam logic [31:0] I_BEQ = 32'h00208463, I_JAL = 32'h000000EF, I_LUI = 32'h12345237;
  localparam logic [31:0] I_SRAI = 32'h4030D293, I_DIV = 32'h027342B3, I_MUL = 32'h027302B3;
  localparam logic [31:0] I_ILL = 32'hFFFFFFFF;

  // fields: regwrite, resultsrc, memwrite, memsize, memsign, jump, branch, alu, alusrc, immsrc, rd, muldiv, illegal
  function automatic logic [24:0] mk(input int rw, rs, mw, sz, sg, j, b, alu, src, imm, rd, md, il);
    return {rw[0], rs[1:0], mw[0], sz[1:0], sg[0], j[0], b[0], alu[4:0], src[0], imm[2:0], rd[4:0],
            md[0], il[0]};
  endfunction

  logic [24:0] c_addi, c_lw2, c_add3, c_lw0, c_sw, c_beq, c_jal, c_lui, c_srai, c_div, c_mul, c_ill;

  task automatic step(input string tag, input int iv, input logic [31:0] ins, input int fl, input int st,
                      input int stall, input int v, input int b, input logic [24:0] c);
    InstrValid = iv[0];
    Instr = ins;
    Flush = fl[0];
    ExStall = st[0];
    st_q.push_back('{tag, stall[0]});
    @(posedge clk);
    #1;
    ex_q.push_back('{tag, v[0], b[0], c, nm_chk});
  endtask

  initial begin
    ex_t e;
    st_t s;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (ex_q.size() != 0) begin
        e = ex_q.pop_front();
        n_cmp++;
        if (ExValid !== e.v || MdBusy !== e.b || got_c !== e.c || (e.nm && n_Illegal !== 1'b1)) begin
          n_bad++;
          $display("FAIL %s: got valid=%b busy=%b ctl=%h nm_illegal=%b, expected valid=%b busy=%b ctl=%h nm_illegal=%s",
                   e.tag, ExValid, MdBusy, got_c, n_Illegal, e.v, e.b, e.c, e.nm ? "1" : "-");
        end
      end
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        n_cmp++;
        if (IdStall !== s.s) begin
          n_bad++;
          $display("FAIL %s IdStall: got %b expected %b", s.tag, IdStall, s.s);
        end
      end
      if (done) begin
        n_cmp++;
        if (ex_q.size() + st_q.size() != 0) begin
          n_bad++;
          $display("FAIL drain: %0d expectations left, expected 0", ex_q.size() + st_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    c_addi = mk(1, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 1, 1, 0, 0);
    c_lw2  = mk(1, 1, 0, 2, 0, 0, 0, 5'b00000, 1, 1, 2, 0, 0);
    c_add3 = mk(1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3, 0, 0);
    c_lw0  = mk(1, 1, 0, 2, 0, 0, 0, 5'b00000, 1, 1, 0, 0, 0);
    c_sw   = mk(0, 0, 1, 2, 0, 0, 0, 5'b00000, 1, 2, 0, 0, 0);
    c_beq  = mk(0, 0, 0, 0, 0, 0, 1, 5'b10000, 0, 3, 0, 0, 0);
    c_jal  = mk(1, 2, 0, 0, 0, 1, 0, 5'b00000, 0, 5, 1, 0, 0);
    c_lui  = mk(1, 0, 0, 1, 1, 0, 0, 5'b01001, 1, 4, 4, 0, 0);
    c_srai = mk(1, 0, 0, 1, 1, 0, 0, 5'b01101, 1, 1, 5, 0, 0);
    c_div  = mk(1, 0, 0, 0, 1, 0, 0, 5'b10100, 0, 0, 5, 1, 0);
    c_mul  = mk(1, 0, 0, 0, 0, 0, 0, 5'b10000, 0, 0, 5, 1, 0);
    c_ill  = mk(0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step("idle",      0, I_ADDI, 0, 0, 0, 0, 0, '0);
    step("addi",      1, I_ADDI, 0, 0, 0, 1, 0, c_addi);
    step("lw_x2",     1, I_LW2,  0, 0, 0, 1, 0, c_lw2);
    step("lu_bubble", 1, I_ADD,  0, 0, 1, 0, 0, '0);
    step("add_x3",    1, I_ADD,  0, 0, 0, 1, 0, c_add3);
    step("lw_x0",     1, I_LW0,  0, 0, 0, 1, 0, c_lw0);
    step("add_nolu",  1, I_ADD0, 0, 0, 0, 1, 0, c_add3);
    step("sw",        1, I_SW,   0, 0, 0, 1, 0, c_sw);
    step("beq",       1, I_BEQ,  0, 0, 0, 1, 0, c_beq);
    step("jal",       1, I_JAL,  0, 0, 0, 1, 0, c_jal);
    step("lui",       1, I_LUI,  0, 0, 0, 1, 0, c_lui);
    step("srai",      1, I_SRAI, 0, 0, 0, 1, 0, c_srai);
    step("lw_x2b",    1, I_LW2,  0, 0, 0, 1, 0, c_lw2);
    step("lu_rs2",    1, I_SW,   0, 0, 1, 0, 0, '0);
    step("sw_after",  1, I_SW,   0, 0, 0, 1, 0, c_sw);
    nm_chk = 1'b1;
    step("div",       1, I_DIV,  0, 0, 0, 1, 1, c_div);
    nm_chk = 1'b0;
    step("div_busy1", 1, I_ADDI, 0, 0, 1, 1, 1, c_div);
    step("div_busy2", 1, I_ADDI, 0, 0, 1, 1, 1, c_div);
    step("div_busy3", 1, I_ADDI, 0, 0, 1, 1, 0, c_div);
    step("after_div", 1, I_ADDI, 0, 0, 0, 1, 0, c_addi);
    step("mul",       1, I_MUL,  0, 0, 0, 1, 0, c_mul);
    step("after_mul", 1, I_ADDI, 0, 0, 0, 1, 0, c_addi);
    step("div_f",     1, I_DIV,  0, 0, 0, 1, 1, c_div);
    step("div_f_b1",  1, I_ADDI, 0, 0, 1, 1, 1, c_div);
    step("flush_md",  1, I_ADDI, 1, 0, 0, 0, 0, '0);
    step("post_fl",   1, I_ADDI, 0, 0, 0, 1, 0, c_addi);
    step("flush_st",  1, I_ADDI, 1, 1, 0, 0, 0, '0);
    step("lw_again",  1, I_LW2,  0, 0, 0, 1, 0, c_lw2);
    step("illegal",   1, I_ILL,  0, 0, 0, 1, 0, c_ill);
    step("add_pre",   1, I_ADD,  0, 0, 0, 1, 0, c_add3);
    step("hold1",     1, I_LW2,  0, 1, 1, 1, 0, c_add3);
    step("hold2",     1, I_LW2,  0, 1, 1, 1, 0, c_add3);
    step("hold3",     1, I_LW2,  0, 1, 1, 1, 0, c_add3);
    step("hold_rel",  1, I_LW2,  0, 0, 0, 1, 0, c_lw2);
    step("div_s",     1, I_DIV,  0, 0, 0, 1, 1, c_div);
    step("div_s_b1",  1, I_ADDI, 0, 0, 1, 1, 1, c_div);
    step("div_s_b2",  1, I_ADDI, 0, 0, 1, 1, 1, c_div);
    step("div_s_exp", 1, I_ADDI, 0, 1, 1, 1, 0, c_div);
    step("div_s_hold",1, I_ADDI, 0, 1, 1, 1, 0, c_div);
    step("div_s_rel", 1, I_ADDI, 0, 0, 0, 1, 0, c_addi);
    step("invalid",   0, I_ADDI, 0, 0, 0, 0, 0, '0);
    step("div_r",     1, I_DIV,  0, 0, 0, 1, 1, c_div);
    @(negedge clk);
    #2;
    ex_q.push_back('{"rst_async", 1'b0, 1'b0, 25'd0, 1'b0});
    st_q.push_back('{"rst_async", 1'b0});
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst0", 0, I_ADDI, 0, 0, 0, 0, 0, '0);
    step("post_rst1", 0, I_ADDI, 0, 0, 0, 0, 0, '0);
    step("post_rst2", 1, I_ADDI, 0, 0, 0, 1, 0, c_addi);
    done = 1'b1;
  end
endmodule
